// File: rtl/write_packer.sv
// Packs PAR_WRITE elements of ROW_SIZE bits into one circular-buffer write word.
// Define WRITE_PACKER_FLUSH_EN to add the flush port for committing partial words.
module write_packer #(
    parameter int ROW_SIZE  = 8,
    parameter int PAR_WRITE = 4,
    localparam int CW       = $clog2(PAR_WRITE + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [ROW_SIZE-1:0]           in_data,
    output logic                          in_ready,
    input  logic                          full,
`ifdef WRITE_PACKER_FLUSH_EN
    input  logic                          flush,
`endif
    output logic                          wen,
    output logic                          update_write_pointer,
    output logic [ROW_SIZE*PAR_WRITE-1:0] dout,
    output logic [CW-1:0]                 count
);

    typedef enum logic {FILL, COMMIT} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic          accept;
    logic          drain;

    // Outputs are masked by reset so nothing leaks while rst is held low.
    assign in_ready             = rst && (state_reg == FILL);
    assign accept               = in_valid && in_ready;
    assign drain                = (state_reg == COMMIT) && !full;
    assign wen                  = rst && drain;
    assign update_write_pointer = wen;
    assign count                = count_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= FILL;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            FILL: begin
                if (accept) begin
                    count_next = count_reg + 1'b1;
                    if (count_next == CW'(PAR_WRITE))
                        state_next = COMMIT;
                end
`ifdef WRITE_PACKER_FLUSH_EN
                // The element accepted alongside flush joins the flushed word.
                if (flush && (accept || (count_reg != '0)))
                    state_next = COMMIT;
`endif
            end
            COMMIT: begin
                if (!full) begin
                    state_next = FILL;
                    count_next = '0;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // One register per lane; a lane captures only when it is the next free slot.
    genvar gi;
    generate
        for (gi = 0; gi < PAR_WRITE; gi++) begin : g_lane
            logic [ROW_SIZE-1:0] lane_reg, lane_next;

            always_comb begin
                lane_next = lane_reg;
                if (drain)
                    lane_next = '0;
                else if (accept && (count_reg == CW'(gi)))
                    lane_next = in_data;
            end

            always_ff @(posedge clk) begin
                if (!rst)
                    lane_reg <= '0;
                else
                    lane_reg <= lane_next;
            end

            assign dout[gi*ROW_SIZE +: ROW_SIZE] = lane_reg;
        end
    endgenerate

endmodule

// File: tb/tb_write_packer.sv
// Directed self-checking bench for write_packer (ROW_SIZE=8, PAR_WRITE=4).
// Inputs change at the falling edge; outputs are sampled 1 time unit later.
module tb_write_packer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        full;
`ifdef WRITE_PACKER_FLUSH_EN
    logic        flush;
`endif
    logic        wen;
    logic        update_write_pointer;
    logic [31:0] dout;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    write_packer #(.ROW_SIZE(8), .PAR_WRITE(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_valid             (in_valid),
        .in_data              (in_data),
        .in_ready             (in_ready),
        .full                 (full),
`ifdef WRITE_PACKER_FLUSH_EN
        .flush                (flush),
`endif
        .wen                  (wen),
        .update_write_pointer (update_write_pointer),
        .dout                 (dout),
        .count                (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        full     = 1'b0;
`ifdef WRITE_PACKER_FLUSH_EN
        flush    = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %b want 0", wen); end
        checks++; if (update_write_pointer !== 1'b0) begin errors++; $display("FAIL reset_uwp got %b want 0", update_write_pointer); end
        checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout got %h want 00000000", dout); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", in_ready); end
        $display("reset done");
        @(negedge clk);
    endtask

    task automatic test_single_word;
        logic [7:0]  data_tab [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [31:0] part_tab [4] = '{32'h0, 32'h11, 32'h2211, 32'h332211};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = data_tab[i];
            #1;
            checks++; if (count !== 3'(i)) begin errors++; $display("FAIL single_count[%0d] got %0d want %0d", i, count, i); end
            checks++; if (dout !== part_tab[i]) begin errors++; $display("FAIL single_partial[%0d] got %h want %h", i, dout, part_tab[i]); end
            checks++; if (wen !== 1'b0) begin errors++; $display("FAIL single_wen_fill[%0d] got %b want 0", i, wen); end
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        checks++; if (wen !== 1'b1) begin errors++; $display("FAIL single_wen got %b want 1", wen); end
        checks++; if (update_write_pointer !== 1'b1) begin errors++; $display("FAIL single_uwp got %b want 1", update_write_pointer); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_ready_commit got %b want 0", in_ready); end
        checks++; if (dout !== 32'h44332211) begin errors++; $display("FAIL single_dout got %h want 44332211", dout); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL single_count_full got %0d want 4", count); end
        $display("single word commit dout=%h", dout);
        @(negedge clk);
        #1;
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL single_wen_after got %b want 0", wen); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_count_after got %0d want 0", count); end
        checks++; if (dout !== 32'h0) begin errors++; $display("FAIL single_dout_after got %h want 00000000", dout); end
        @(negedge clk);
    endtask

    task automatic test_full_stall;
        logic [7:0] data_tab [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = data_tab[i];
            @(negedge clk);
        end
        in_data = 8'hEE;
        for (int j = 0; j < 3; j++) begin
            #1;
            checks++; if (wen !== 1'b0) begin errors++; $display("FAIL stall_wen[%0d] got %b want 0", j, wen); end
            checks++; if (update_write_pointer !== 1'b0) begin errors++; $display("FAIL stall_uwp[%0d] got %b want 0", j, update_write_pointer); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %b want 0", j, in_ready); end
            checks++; if (dout !== 32'hDDCCBBAA) begin errors++; $display("FAIL stall_dout[%0d] got %h want ddccbbaa", j, dout); end
            checks++; if (count !== 3'd4) begin errors++; $display("FAIL stall_count[%0d] got %0d want 4", j, count); end
            $display("stall cycle %0d dout=%h", j, dout);
            @(negedge clk);
        end
        full     = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++; if (wen !== 1'b1) begin errors++; $display("FAIL stall_release_wen got %b want 1", wen); end
        checks++; if (dout !== 32'hDDCCBBAA) begin errors++; $display("FAIL stall_release_dout got %h want ddccbbaa", dout); end
        @(negedge clk);
        #1;
        checks++; if (dout !== 32'h0) begin errors++; $display("FAIL stall_after_dout got %h want 00000000", dout); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL stall_after_count got %0d want 0", count); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int          accepted = 0;
        int          pulses   = 0;
        int          last_pulse = 0;
        logic [31:0] exp_word;
        full     = 1'b0;
        in_valid = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            in_data = 8'(accepted + 1);
            #1;
            checks++; if (wen !== ((cyc % 5) == 0)) begin errors++; $display("FAIL b2b_wen[%0d] got %b want %b", cyc, wen, (cyc % 5) == 0); end
            checks++; if (in_ready !== ((cyc % 5) != 0)) begin errors++; $display("FAIL b2b_ready[%0d] got %b want %b", cyc, in_ready, (cyc % 5) != 0); end
            if (wen === 1'b1) begin
                exp_word = {8'(4*pulses + 4), 8'(4*pulses + 3), 8'(4*pulses + 2), 8'(4*pulses + 1)};
                checks++; if (dout !== exp_word) begin errors++; $display("FAIL b2b_dout[%0d] got %h want %h", pulses, dout, exp_word); end
                if (pulses > 0) begin
                    checks++; if (cyc - last_pulse !== 5) begin errors++; $display("FAIL b2b_spacing[%0d] got %0d want 5", pulses, cyc - last_pulse); end
                end
                $display("b2b commit %0d cycle %0d dout=%h", pulses, cyc, dout);
                last_pulse = cyc;
                pulses++;
            end
            if (in_ready === 1'b1) accepted++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (accepted !== 16) begin errors++; $display("FAIL b2b_accepted got %0d want 16", accepted); end
        checks++; if (pulses !== 4) begin errors++; $display("FAIL b2b_pulses got %0d want 4", pulses); end
        @(negedge clk);
    endtask

    task automatic test_reset_in_commit;
        logic [7:0] data_tab [4] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = data_tab[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        checks++; if (dout !== 32'hAABBCCDD) begin errors++; $display("FAIL rstc_held_dout got %h want aabbccdd", dout); end
        rst  = 1'b0;
        full = 1'b0;
        #1;
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL rstc_wen_in_rst got %b want 0", wen); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstc_ready_in_rst got %b want 0", in_ready); end
        @(negedge clk);
        #1;
        checks++; if (dout !== 32'h0) begin errors++; $display("FAIL rstc_dout got %h want 00000000", dout); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rstc_count got %0d want 0", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstc_ready_held got %b want 0", in_ready); end
        rst = 1'b1;
        #1;
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL rstc_wen_after got %b want 0", wen); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstc_ready_after got %b want 1", in_ready); end
        $display("reset in commit discarded word");
        @(negedge clk);
    endtask

`ifdef WRITE_PACKER_FLUSH_EN
    task automatic test_flush;
        in_valid = 1'b1;
        in_data  = 8'h01;
        @(negedge clk);
        in_data  = 8'h02;
        @(negedge clk);
        in_data  = 8'h03;
        flush    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        checks++; if (wen !== 1'b1) begin errors++; $display("FAIL flush_wen got %b want 1", wen); end
        checks++; if (dout !== 32'h00030201) begin errors++; $display("FAIL flush_dout got %h want 00030201", dout); end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_count got %0d want 3", count); end
        $display("flush commit dout=%h", dout);
        @(negedge clk);
        #1;
        checks++; if (dout !== 32'h0) begin errors++; $display("FAIL flush_after_dout got %h want 00000000", dout); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_after_count got %0d want 0", count); end
        @(negedge clk);
    endtask

    task automatic test_flush_empty;
        flush    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL flush_empty_wen got %b want 0", wen); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_empty_ready got %b want 1", in_ready); end
        $display("flush with empty packer ignored");
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_full_stall();
        test_back_to_back();
        test_reset_in_commit();
`ifdef WRITE_PACKER_FLUSH_EN
        test_flush();
        test_flush_empty();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/write_packer.md
WRITE_PACKER -- requirements
Module: write_packer

Interface
REQ-001 Parameter ROW_SIZE, default 8, SHALL set the width in bits of one element.
REQ-002 Parameter PAR_WRITE, default 4, SHALL set the number of elements packed into one buffer write word.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, synchronous and active-low (reset when rst=0 at a rising clk edge).
REQ-005 in_valid  input  1  SHALL indicate that in_data holds an element offered by the producer.
REQ-006 in_data  input  ROW_SIZE  SHALL be the offered element.
REQ-007 in_ready  output  1  SHALL indicate the packer accepts in_data this cycle; an element transfers when in_valid=1 and in_ready=1 at a rising edge.
REQ-008 full  input  1  SHALL be the downstream circular buffer full flag.
REQ-009 wen  output  1  SHALL be the buffer write enable.
REQ-010 update_write_pointer  output  1  SHALL advance the buffer write pointer by PAR_WRITE.
REQ-011 dout  output  ROW_SIZE*PAR_WRITE  SHALL be the packed word presented to the buffer din.
REQ-012 count  output  $clog2(PAR_WRITE+1)  SHALL report the number of elements currently held.
REQ-013 flush  input  1  SHALL request commit of a partial word; present only when WRITE_PACKER_FLUSH_EN is defined.

Function
REQ-014 The FSM SHALL have exactly two states: FILL and COMMIT.
REQ-015 In FILL, in_ready SHALL be 1, and wen and update_write_pointer SHALL be 0.
REQ-016 Each accepted element SHALL be stored in lane count, bits [count*ROW_SIZE +: ROW_SIZE] of dout, and count SHALL increment by 1.
REQ-017 The first accepted element of a word SHALL occupy bits [ROW_SIZE-1:0].
REQ-018 When an accept brings count to PAR_WRITE, the FSM SHALL move to COMMIT on that same edge.
REQ-019 In COMMIT, in_ready SHALL be 0.
REQ-020 In COMMIT with full=0, wen and update_write_pointer SHALL both be 1 for that cycle, decoded combinationally from state and full.
REQ-021 After a COMMIT cycle with full=0, the next edge SHALL clear count and all dout lanes to 0 and return the FSM to FILL.
REQ-022 In COMMIT with full=1, wen and update_write_pointer SHALL be 0, and state, count and dout SHALL hold unchanged until full=0.
REQ-023 Latency: if the PAR_WRITE-th element is accepted at edge N, wen SHALL be 1 in the cycle after edge N, provided full=0.
REQ-024 Sustained throughput SHALL be PAR_WRITE elements per PAR_WRITE+1 cycles.
REQ-025 dout SHALL stay stable throughout COMMIT.
REQ-026 Lanes not yet written SHALL read 0.
REQ-027 An element offered while in_ready=0 SHALL NOT be stored.

Reset
REQ-028 With rst=0 at a rising edge, the state SHALL become FILL, count SHALL become 0, and dout SHALL become 0.
REQ-029 While rst=0, wen, update_write_pointer and in_ready SHALL be 0.
REQ-030 Reset during COMMIT SHALL discard the held word; no write SHALL be issued in the cycle after reset.

Configuration
REQ-031 With macro WRITE_PACKER_FLUSH_EN defined, the flush port SHALL exist.
REQ-032 With WRITE_PACKER_FLUSH_EN defined, flush=1 in FILL SHALL move the FSM to COMMIT if count after that cycle's accept (if any) is greater than 0; the element accepted in that cycle is included.
REQ-033 With WRITE_PACKER_FLUSH_EN defined, a flushed word SHALL have its unused lanes at 0 and SHALL still advance the pointer by PAR_WRITE.
REQ-034 With WRITE_PACKER_FLUSH_EN defined, flush=1 with count=0 and no accept SHALL be a no-op, and flush SHALL be ignored in COMMIT.
REQ-035 Without WRITE_PACKER_FLUSH_EN, the flush port and its logic SHALL be absent, and only full words SHALL be committed.

Verification
REQ-036 Reset, then elements 0x11,0x22,0x33,0x44 on consecutive cycles with full=0 -> exactly one wen pulse in cycle 5; dout=0x44332211; count returns to 0.
REQ-037 Fill 4 elements while full=1 for 3 cycles -> wen=0 and in_ready=0 for those 3 cycles, dout held; wen=1 in the first cycle with full=0.
REQ-038 Continuous in_valid=1 for 20 cycles, full=0 -> exactly 16 elements accepted, 4 wen pulses spaced 5 cycles apart, element order preserved.
REQ-039 rst=0 asserted in COMMIT with dout=0xAABBCCDD -> the next cycle has wen=0, dout=0, count=0, and in_ready=0 while rst=0.
REQ-040 With WRITE_PACKER_FLUSH_EN: accept 0x01,0x02, then flush=1 together with in_valid=1 and 0x03 -> wen next cycle, dout=0x00030201.
REQ-041 With WRITE_PACKER_FLUSH_EN: flush=1 with count=0 -> no wen pulse and state stays FILL.
